// File: rtl/csi2_rx_pkg.sv
// Shared types for the CSI-2 receive controller: controller state encoding
// and a small state classification helper.
package csi2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // States in which the D-PHY is enabled and the watchdog runs.
  function automatic logic is_running(input state_e s);
    return (s == ST_ARM) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/csi2_rx_ctrl_if.sv
// Command/status bundle of the CSI-2 receive controller, seen from the
// controller (master) and from the host/packet side (slave).
interface csi2_rx_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start;
  logic                 stop;
  logic                 frame_start;
  logic                 frame_end;
  logic                 pkt_error;
  logic                 enable;
  logic                 pipe_rst;
  logic [1:0]           state;
  logic                 in_frame;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0] error_cnt;
  logic                 timeout;

  modport master (
    input  start, stop, frame_start, frame_end, pkt_error,
    output enable, pipe_rst, state, in_frame, frame_cnt, error_cnt, timeout
  );

  modport slave (
    output start, stop, frame_start, frame_end, pkt_error,
    input  enable, pipe_rst, state, in_frame, frame_cnt, error_cnt, timeout
  );
endinterface

// File: rtl/csi2_rx_watchdog.sv
// Frame-activity watchdog: counts quiet cycles while running and flags the
// TIMEOUT_CYCLES-th consecutive quiet cycle.
module csi2_rx_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count quiet running cycles; stopping, any frame marker or expiry restarts from zero.
  always_comb begin
    expire_o = run_i && !clear_i && (cnt_q == LAST);
    if (!run_i || clear_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Quiet-cycle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csi2_rx_ctrl.sv
// CSI-2 receive controller: D-PHY enable sequencing, frame tracking, error
// recovery with pipeline reset, and frame/error statistics.
module csi2_rx_ctrl
  import csi2_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RECOVER_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 frame_start_i,
  input  logic                 frame_end_i,
  input  logic                 pkt_error_i,
  output logic                 enable_o,
  output logic                 pipe_rst_o,
  output logic [1:0]           state_o,
  output logic                 in_frame_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic [CNT_WIDTH-1:0] error_cnt_o,
  output logic                 timeout_o
);

  localparam int unsigned RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 in_frame_q, in_frame_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 enable_q, enable_d;
  logic                 pipe_rst_q, pipe_rst_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] error_cnt_q, error_cnt_d;
  logic [RW-1:0]        rec_cnt_q, rec_cnt_d;
  logic                 err_evt;
  logic                 frame_done;
  logic                 wd_expire;

  csi2_rx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (is_running(state_q)),
    .clear_i (frame_start_i | frame_end_i),
    .expire_o(wd_expire)
  );

  // State and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      in_frame_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      enable_q    <= 1'b0;
      pipe_rst_q  <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
      error_cnt_q <= '0;
      rec_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_frame_q  <= in_frame_d;
      stop_pend_q <= stop_pend_d;
      enable_q    <= enable_d;
      pipe_rst_q  <= pipe_rst_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
      error_cnt_q <= error_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
    end
  end

  // Next state: packet errors outrank frame markers, which outrank the watchdog.
  always_comb begin
    state_d     = state_q;
    in_frame_d  = in_frame_q;
    stop_pend_d = stop_pend_q | stop_i;
    timeout_d   = 1'b0;
    err_evt     = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start_i && !stop_i) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (pkt_error_i) begin
          err_evt = 1'b1;
          state_d = ST_RECOVER;
        end else if (stop_i) begin
          state_d = ST_IDLE;
        end else if (frame_start_i) begin
          state_d    = ST_ACTIVE;
          in_frame_d = 1'b1;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          err_evt   = 1'b1;
          state_d   = ST_RECOVER;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_ACTIVE: begin
        if (pkt_error_i) begin
          err_evt = 1'b1;
          state_d = ST_RECOVER;
        end else if (in_frame_q && frame_end_i) begin
          // A same-cycle FS opens the next frame immediately.
          frame_done = 1'b1;
          in_frame_d = frame_start_i;
          if (stop_pend_d) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else if (in_frame_q ? frame_start_i : frame_end_i) begin
          err_evt = 1'b1;
          state_d = ST_RECOVER;
        end else if (!in_frame_q && stop_i) begin
          state_d = ST_IDLE;
        end else if (frame_start_i) begin
          in_frame_d = 1'b1;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          err_evt   = 1'b1;
          state_d   = ST_RECOVER;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_RECOVER: begin
        if (rec_cnt_q == REC_LAST) begin
          state_d = stop_pend_d ? ST_IDLE : ST_ARM;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!is_running(state_d)) begin
      in_frame_d = 1'b0;
    end else begin
      in_frame_d = in_frame_d & (state_d == ST_ACTIVE);
    end
    if (state_d == ST_IDLE) begin
      stop_pend_d = 1'b0;
    end else begin
      stop_pend_d = stop_pend_d;
    end
    if ((state_q == ST_RECOVER) && (state_d == ST_RECOVER)) begin
      rec_cnt_d = rec_cnt_q + RW'(1);
    end else begin
      rec_cnt_d = '0;
    end
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (err_evt && (error_cnt_q != '1)) begin
      error_cnt_d = error_cnt_q + CNT_WIDTH'(1);
    end else begin
      error_cnt_d = error_cnt_q;
    end
  end

  // Output decode from the upcoming state; any return to IDLE flushes the pipeline once.
  always_comb begin
    enable_d   = is_running(state_d);
    pipe_rst_d = (state_d == ST_RECOVER) || ((state_d == ST_IDLE) && (state_q != ST_IDLE));
  end

  assign enable_o    = enable_q;
  assign pipe_rst_o  = pipe_rst_q;
  assign state_o     = state_q;
  assign in_frame_o  = in_frame_q;
  assign frame_cnt_o = frame_cnt_q;
  assign error_cnt_o = error_cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_csi2_rx_ctrl.sv
// Bench for csi2_rx_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_csi2_rx_ctrl;

  localparam int TMO = 100;
  localparam int REC = 16;

  bit clk = 1'b0;
  bit rst, start, stop, fs, fe, perr;
  bit chk_en = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  csi2_rx_ctrl_if #(.CNT_WIDTH(8)) bus ();
  assign bus.start       = start;
  assign bus.stop        = stop;
  assign bus.frame_start = fs;
  assign bus.frame_end   = fe;
  assign bus.pkt_error   = perr;

  csi2_rx_ctrl #(.TIMEOUT_CYCLES(TMO), .RECOVER_CYCLES(REC), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(bus.start), .stop_i(bus.stop),
    .frame_start_i(bus.frame_start), .frame_end_i(bus.frame_end), .pkt_error_i(bus.pkt_error),
    .enable_o(bus.enable), .pipe_rst_o(bus.pipe_rst), .state_o(bus.state),
    .in_frame_o(bus.in_frame), .frame_cnt_o(bus.frame_cnt), .error_cnt_o(bus.error_cnt),
    .timeout_o(bus.timeout)
  );

  logic       d2_en, d2_pr, d2_inf, d2_to;
  logic [1:0] d2_st, d2_fc, d2_ec;

  csi2_rx_ctrl #(.TIMEOUT_CYCLES(TMO), .RECOVER_CYCLES(REC), .CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .frame_start_i(fs), .frame_end_i(fe), .pkt_error_i(perr),
    .enable_o(d2_en), .pipe_rst_o(d2_pr), .state_o(d2_st),
    .in_frame_o(d2_inf), .frame_cnt_o(d2_fc), .error_cnt_o(d2_ec),
    .timeout_o(d2_to)
  );

  // Behavioural model, one slot per DUT (slot 1 has 2-bit counters).
  int cmax [2] = '{255, 3};
  int m_st [2], m_fc [2], m_ec [2], m_quiet [2], m_rc [2];
  bit m_inf [2], m_sp [2], m_en [2], m_pr [2], m_to [2];

  task automatic model_step(input int i);
    int  nst;
    bit  err, done, to, kick, expire, stop_req, running;
    if (rst) begin
      m_st[i] = 0; m_fc[i] = 0; m_ec[i] = 0; m_quiet[i] = 0; m_rc[i] = 0;
      m_inf[i] = 0; m_sp[i] = 0; m_en[i] = 0; m_pr[i] = 0; m_to[i] = 0;
      return;
    end
    kick     = fs || fe;
    running  = (m_st[i] == 1) || (m_st[i] == 2);
    expire   = running && !kick && (m_quiet[i] + 1 == TMO);
    stop_req = m_sp[i] || (stop && m_st[i] != 0);
    nst = m_st[i]; err = 0; done = 0; to = 0;
    if (m_st[i] == 0) begin
      if (start && !stop) nst = 1;
    end else if (m_st[i] == 3) begin
      if (m_rc[i] + 1 == REC) nst = stop_req ? 0 : 1;
    end else if (perr) begin
      err = 1;
    end else if (m_st[i] == 1) begin
      if (stop) nst = 0;
      else if (fs) begin nst = 2; m_inf[i] = 1; end
      else if (expire) to = 1;
    end else if (m_inf[i]) begin
      if (fe) begin done = 1; m_inf[i] = fs; if (stop_req) nst = 0; end
      else if (fs) err = 1;
      else if (expire) to = 1;
    end else begin
      if (fe) err = 1;
      else if (stop) nst = 0;
      else if (fs) m_inf[i] = 1;
      else if (expire) to = 1;
    end
    if (to) err = 1;
    if (err) nst = 3;
    if (nst != 2) m_inf[i] = 0;
    m_quiet[i] = ((nst == 1 || nst == 2) && nst == m_st[i] && !kick) ? m_quiet[i] + 1 : 0;
    m_rc[i]  = (nst == 3 && m_st[i] == 3) ? m_rc[i] + 1 : 0;
    m_pr[i]  = (nst == 3) || (nst == 0 && m_st[i] != 0);
    m_en[i]  = (nst == 1) || (nst == 2);
    m_to[i]  = to;
    m_sp[i]  = (nst == 0) ? 1'b0 : stop_req;
    m_fc[i]  = (m_fc[i] + int'(done)) % (cmax[i] + 1);
    if (err && m_ec[i] < cmax[i]) m_ec[i] = m_ec[i] + 1;
    m_st[i]  = nst;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state", int'(bus.state), m_st[0]);
      cmp("enable", int'(bus.enable), int'(m_en[0]));
      cmp("pipe_rst", int'(bus.pipe_rst), int'(m_pr[0]));
      cmp("in_frame", int'(bus.in_frame), int'(m_inf[0]));
      cmp("frame_cnt", int'(bus.frame_cnt), m_fc[0]);
      cmp("error_cnt", int'(bus.error_cnt), m_ec[0]);
      cmp("timeout", int'(bus.timeout), int'(m_to[0]));
      cmp("w2_state", int'(d2_st), m_st[1]);
      cmp("w2_pipe_rst", int'(d2_pr), int'(m_pr[1]));
      cmp("w2_frame_cnt", int'(d2_fc), m_fc[1]);
      cmp("w2_error_cnt", int'(d2_ec), m_ec[1]);
      cmp("w2_misc", int'({d2_en, d2_inf, d2_to}), int'({m_en[1], m_inf[1], m_to[1]}));
    end
  end

  task automatic step(input bit s, input bit p, input bit a, input bit e, input bit r, input bit x);
    start = s; stop = p; fs = a; fe = e; perr = r; rst = x;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    start = 0; stop = 0; fs = 0; fe = 0; perr = 0; rst = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_state(input int s, input int bound);
    for (int k = 0; k < bound && int'(bus.state) != s; k++) idle();
    cmp("wait_state", int'(bus.state), s);
  endtask

  int n;
  int p_fs, p_fe, p_st, p_sp, p_pe;

  initial begin
    step(0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(1, 0, 1, 1, 1, 1);
    cmp("rst_state", int'(bus.state), 0);
    cmp("rst_outs", int'({bus.enable, bus.pipe_rst, bus.in_frame, bus.timeout}), 0);
    cmp("rst_cnts", int'(bus.frame_cnt) + int'(bus.error_cnt), 0);

    // Start and two clean frames.
    step(1, 0, 0, 0, 0, 0);
    cmp("arm_state", int'(bus.state), 1);
    cmp("arm_enable", int'(bus.enable), 1);
    step(0, 0, 1, 0, 0, 0);
    cmp("active_state", int'(bus.state), 2);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    cmp("two_frames", int'(bus.frame_cnt), 2);
    cmp("two_frames_err", int'(bus.error_cnt), 0);
    // Back-to-back FE+FS inside a frame.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    cmp("fefs_frames", int'(bus.frame_cnt), 3);
    cmp("fefs_in_frame", int'(bus.in_frame), 1);
    cmp("fefs_err", int'(bus.error_cnt), 0);

    // Packet error mid-frame: 16 cycles of pipeline reset, then ARM.
    step(0, 0, 0, 0, 1, 0);
    cmp("perr_state", int'(bus.state), 3);
    cmp("perr_enable", int'(bus.enable), 0);
    n = int'(bus.pipe_rst);
    for (int k = 0; k < 40 && int'(bus.state) == 3; k++) begin
      idle();
      n += int'(bus.pipe_rst);
    end
    cmp("recover_len", n, 16);
    cmp("recover_exit", int'(bus.state), 1);
    cmp("perr_errcnt", int'(bus.error_cnt), 1);

    // Watchdog: nothing arrives after ARM entry.
    n = 0;
    while (!bus.timeout && n < 200) begin
      idle();
      n++;
    end
    cmp("timeout_delay", n, 100);
    cmp("timeout_state", int'(bus.state), 3);
    cmp("timeout_errcnt", int'(bus.error_cnt), 2);
    wait_state(1, 40);

    // Stop mid-frame waits for FE.
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    cmp("stop_pending_state", int'(bus.state), 2);
    step(0, 0, 0, 1, 0, 0);
    cmp("stop_idle", int'(bus.state), 0);
    cmp("stop_frames", int'(bus.frame_cnt), 4);
    cmp("stop_flush", int'({bus.enable, bus.pipe_rst}), 1);
    idle();
    cmp("stop_flush_end", int'(bus.pipe_rst), 0);

    // FS, FS without FE.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    cmp("fsfs_state", int'(bus.state), 3);
    cmp("fsfs_errcnt", int'(bus.error_cnt), 3);

    // Reset while recovering.
    step(0, 0, 0, 0, 0, 1);
    cmp("rst_rec_state", int'(bus.state), 0);
    cmp("rst_rec_outs", int'({bus.enable, bus.pipe_rst, bus.in_frame, bus.timeout}), 0);

    // Five errors saturate a 2-bit error counter.
    step(1, 0, 0, 0, 0, 0);
    for (int e = 0; e < 5; e++) begin
      step(0, 0, 0, 0, 1, 0);
      wait_state(1, 40);
    end
    cmp("sat_w2", int'(d2_ec), 3);
    cmp("sat_w8", int'(bus.error_cnt), 5);
    step(0, 1, 0, 0, 0, 0);

    // Randomized segments with varying traffic density.
    for (int seg = 0; seg < 30; seg++) begin
      p_fs = $urandom_range(0, 12);
      p_fe = $urandom_range(0, 12);
      p_st = $urandom_range(1, 15);
      p_sp = $urandom_range(0, 3);
      p_pe = $urandom_range(0, 2);
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(0, 99) < p_st, $urandom_range(0, 99) < p_sp,
             $urandom_range(0, 99) < p_fs, $urandom_range(0, 99) < p_fe,
             $urandom_range(0, 199) < p_pe, $urandom_range(0, 999) < 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csi2_rx_ctrl.md
CSI2_RX_CTRL -- requirements
Module: csi2_rx_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max clk_i cycles without frame_start_i/frame_end_i before recovery.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 16, cycles pipe_rst_o is held during recovery (>=1).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of frame and error counters.
REQ-004 SHALL have port clk_i  input  1  pixel clock, the single clock.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  input  1  single-cycle start-streaming command.
REQ-007 SHALL have port stop_i  input  1  single-cycle stop-streaming command.
REQ-008 SHALL have port frame_start_i  input  1  pulse, Frame Start packet from packet handler.
REQ-009 SHALL have port frame_end_i  input  1  pulse, Frame End packet from packet handler.
REQ-010 SHALL have port pkt_error_i  input  1  pulse, uncorrectable header error, already in clk_i domain.
REQ-011 SHALL have port enable_o  output  1  D-PHY slave enable.
REQ-012 SHALL have port pipe_rst_o  output  1  reset for CDC FIFO and downstream packet pipeline.
REQ-013 SHALL have port state_o  output  2  current state encoding.
REQ-014 SHALL have port in_frame_o  output  1  high between accepted FS and FE.
REQ-015 SHALL have port frame_cnt_o  output  CNT_WIDTH  completed frames.
REQ-016 SHALL have port error_cnt_o  output  CNT_WIDTH  error/recovery events.
REQ-017 SHALL have port timeout_o  output  1  single-cycle watchdog-expiry pulse.

Function
REQ-018 SHALL implement states IDLE=0, ARM=1, ACTIVE=2, RECOVER=3; all outputs registered, one-cycle latency from causing input.
REQ-019 IDLE: enable_o=0, pipe_rst_o=0; start_i -> ARM.
REQ-020 ARM: enable_o=1; frame_start_i -> ACTIVE with in_frame_o=1.
REQ-021 ACTIVE: enable_o=1; frame_end_i with in_frame_o=1 -> in_frame_o=0, frame_cnt_o+1 (wraps); frame_start_i with in_frame_o=0 -> in_frame_o=1.
REQ-022 ACTIVE: frame_end_i with in_frame_o=0, or frame_start_i with in_frame_o=1 (FE missing), SHALL count an error and enter RECOVER.
REQ-023 ACTIVE: simultaneous frame_end_i and frame_start_i with in_frame_o=1 -> frame counted, in_frame_o stays 1, no error.
REQ-024 pkt_error_i in ARM or ACTIVE -> error_cnt_o+1, RECOVER; ignored in IDLE and RECOVER; takes priority over same-cycle FS/FE (frame not counted).
REQ-025 Watchdog counts in ARM/ACTIVE, clears on any FS/FE and on state entry; reaching TIMEOUT_CYCLES -> timeout_o pulse, error_cnt_o+1, RECOVER.
REQ-026 RECOVER: enable_o=0, pipe_rst_o=1, in_frame_o=0 for exactly RECOVER_CYCLES cycles, then ARM, or IDLE if a stop is pending.
REQ-027 stop_i: IDLE ignored; ARM -> IDLE next cycle; ACTIVE with in_frame_o=0 -> IDLE; ACTIVE with in_frame_o=1 -> stop pending, IDLE after the next FE (frame counted); RECOVER -> stop pending.
REQ-028 Stop pending SHALL clear on entry to IDLE; start_i while not IDLE ignored; start_i and stop_i together: stop wins.
REQ-029 error_cnt_o SHALL saturate at all ones; frame_cnt_o SHALL wrap.
REQ-030 Entering IDLE from any state SHALL assert pipe_rst_o for one cycle to flush partial packets.

Reset
REQ-031 rst_i SHALL force IDLE; enable_o, pipe_rst_o, in_frame_o, timeout_o, state_o, counters, watchdog, stop pending all 0, next cycle, regardless of state.

Structure
REQ-032 State enum and its 2-bit encoding SHALL live in shared package csi2_rx_pkg.
REQ-033 Watchdog SHALL be sub-module csi2_rx_watchdog (clear, run, expire pulse, TIMEOUT_CYCLES parameter).

Verification
REQ-034 start_i, FS, FE, FS, FE -> states 0->1->2, frame_cnt_o=2, error_cnt_o=0, enable_o=1.
REQ-035 ACTIVE in frame, pkt_error_i -> state 3, pipe_rst_o high 16 cycles, enable_o=0, then state 1, error_cnt_o=1.
REQ-036 TIMEOUT_CYCLES=100, start_i, no FS -> timeout_o pulse 100 cycles after ARM entry, RECOVER, error_cnt_o=1.
REQ-037 stop_i mid-frame -> stays ACTIVE until FE, frame_cnt_o+1, then IDLE, enable_o=0, one-cycle pipe_rst_o.
REQ-038 FS, FS without FE -> error_cnt_o=1, RECOVER; FE+FS same cycle in frame -> frame counted, no error.
REQ-039 rst_i asserted in RECOVER -> all outputs 0, state IDLE next cycle; CNT_WIDTH=2 with 5 errors -> error_cnt_o=3.
